// File: rtl/ram_access_arbiter.sv
// Arbitrates the single-port game RAM between the transaction side and the display side.
// One access in flight; transaction side wins ties until the display has waited MAX_TXN_BURST grants.
module ram_access_arbiter #(
  parameter int DATA_W        = 48,
  parameter int ADDR_W        = 1,
  parameter int READ_LATENCY  = 2,
  parameter int MAX_TXN_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              txn_req,
  input  logic              txn_wr,
  input  logic [ADDR_W-1:0] txn_addr,
  input  logic [DATA_W-1:0] txn_wdata,
  output logic              txn_ack,
  output logic              txn_rvalid,
  output logic [DATA_W-1:0] txn_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  localparam int LAT_W   = $clog2(READ_LATENCY + 1);
  localparam int BURST_W = $clog2(MAX_TXN_BURST + 1);
  localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0]   LAT_ONE   = LAT_W'(1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_TXN_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                owner_disp_r, owner_disp_s;  // 1 = display side owns the access
  logic                wr_r, wr_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic [LAT_W-1:0]    lat_cnt_r, lat_cnt_s;
  logic [BURST_W-1:0]  burst_cnt_r, burst_cnt_s;
  logic                capture_s;

  // Next-state, latch and counter logic
  always_comb begin
    state_s      = state_r;
    owner_disp_s = owner_disp_r;
    wr_s         = wr_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    lat_cnt_s    = lat_cnt_r;
    burst_cnt_s  = burst_cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (txn_req && !(disp_req && (burst_cnt_r == BURST_MAX))) begin
          state_s      = ISSUE;
          owner_disp_s = 1'b0;
          wr_s         = txn_wr;
          addr_s       = txn_addr;
          wdata_s      = txn_wdata;
          // only grants that made the display wait count toward the burst limit
          if (disp_req) begin
            burst_cnt_s = burst_cnt_r + BURST_ONE;
          end else begin
            burst_cnt_s = {BURST_W{1'b0}};
          end
        end else if (disp_req) begin
          state_s      = ISSUE;
          owner_disp_s = 1'b1;
          wr_s         = 1'b0;
          addr_s       = disp_addr;
          wdata_s      = {DATA_W{1'b0}};
          burst_cnt_s  = {BURST_W{1'b0}};
        end else begin
          burst_cnt_s  = {BURST_W{1'b0}};
        end
      end
      ISSUE: begin
        if (wr_r) begin
          state_s = IDLE;
        end else begin
          state_s   = WAIT;
          lat_cnt_s = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_cnt_r == LAT_ONE) begin
          state_s   = RESP;
          lat_cnt_s = {LAT_W{1'b0}};
          capture_s = 1'b1;
        end else begin
          lat_cnt_s = lat_cnt_r - LAT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_disp_r <= 1'b0;
      wr_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      lat_cnt_r    <= {LAT_W{1'b0}};
      burst_cnt_r  <= {BURST_W{1'b0}};
      txn_ack      <= 1'b0;
      disp_ack     <= 1'b0;
      txn_rvalid   <= 1'b0;
      disp_rvalid  <= 1'b0;
      txn_rdata    <= {DATA_W{1'b0}};
      disp_rdata   <= {DATA_W{1'b0}};
      ram_address  <= {ADDR_W{1'b0}};
      ram_wren     <= 1'b0;
      ram_data     <= {DATA_W{1'b0}};
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      owner_disp_r <= owner_disp_s;
      wr_r         <= wr_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      lat_cnt_r    <= lat_cnt_s;
      burst_cnt_r  <= burst_cnt_s;
      // outputs are computed from the next state so they line up with it
      txn_ack      <= (state_s == ISSUE) && !owner_disp_s;
      disp_ack     <= (state_s == ISSUE) && owner_disp_s;
      txn_rvalid   <= (state_s == RESP) && !owner_disp_s;
      disp_rvalid  <= (state_s == RESP) && owner_disp_s;
      ram_wren     <= (state_s == ISSUE) && wr_s;
      busy         <= (state_s != IDLE);
      if (state_s == ISSUE) begin
        ram_address <= addr_s;
        ram_data    <= wdata_s;
      end
      if (capture_s && !owner_disp_r) begin
        txn_rdata <= ram_q;
      end
      if (capture_s && owner_disp_r) begin
        disp_rdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a 2-cycle-latency RAM model.
// Expected ack/rvalid events are queued by the stimulus; a negedge monitor pops and compares.
module tb_ram_access_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        txn_req, txn_wr;
  logic [0:0]  txn_addr;
  logic [47:0] txn_wdata;
  logic        txn_ack, txn_rvalid;
  logic [47:0] txn_rdata;
  logic        disp_req;
  logic [0:0]  disp_addr;
  logic        disp_ack, disp_rvalid;
  logic [47:0] disp_rdata;
  logic [0:0]  ram_address;
  logic        ram_wren;
  logic [47:0] ram_data;
  logic [47:0] ram_q;
  logic        busy;

  ram_access_arbiter dut (
    .clock(clock), .reset(reset),
    .txn_req(txn_req), .txn_wr(txn_wr), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
    .txn_ack(txn_ack), .txn_rvalid(txn_rvalid), .txn_rdata(txn_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_ack(disp_ack), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM model: registered address, one output register (read latency 2)
  logic [47:0] mem [0:1];
  logic [0:0]  ram_addr_q;
  initial begin
    mem[0] = 48'h0000_0000_1234;
    mem[1] = 48'h0;
    ram_addr_q = 1'b0;
    ram_q = 48'h0;
  end
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_addr_q <= ram_address;
    ram_q      <= mem[ram_addr_q];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wren_cycles = 0;
  int ack_cyc = 0;

  // kind: 0 txn_ack, 1 disp_ack, 2 txn_rvalid, 3 disp_rvalid
  typedef struct packed {
    logic [1:0]  kind;
    logic        wr;
    logic [47:0] data;
    logic [47:0] other;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic wr, input logic [47:0] data,
                      input logic [47:0] other);
    exp_t x;
    x.kind = kind; x.wr = wr; x.data = data; x.other = other;
    sb.push_back(x);
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset && ram_wren) wren_cycles++;
  end

  // Monitor: every ack/rvalid pulse must match the head of the scoreboard
  always @(negedge clock) begin
    logic [1:0] kind;
    if (!reset && (txn_ack || disp_ack || txn_rvalid || disp_rvalid)) begin
      check("one_event", 64'($countones({txn_ack, disp_ack, txn_rvalid, disp_rvalid})), 64'd1);
      kind = txn_ack ? 2'd0 : disp_ack ? 2'd1 : txn_rvalid ? 2'd2 : 2'd3;
      if (sb.size() == 0) begin
        check("unexpected_event", 64'(kind), 64'hFF);
      end else begin
        e = sb.pop_front();
        check("event_kind", 64'(kind), 64'(e.kind));
        if (kind < 2'd2) begin
          check("wren_at_ack", 64'(ram_wren), 64'(e.wr));
          ack_cyc = cyc;
        end else begin
          check("read_latency", 64'(cyc - ack_cyc), 64'd3);
          if (kind == 2'd2) begin
            check("txn_rdata", 64'(txn_rdata), 64'(e.data));
            check("disp_rdata_kept", 64'(disp_rdata), 64'(e.other));
          end else begin
            check("disp_rdata", 64'(disp_rdata), 64'(e.data));
            check("txn_rdata_kept", 64'(txn_rdata), 64'(e.other));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 64'($countones({txn_ack, txn_rvalid, txn_rdata, disp_ack, disp_rvalid, disp_rdata,
                               ram_address, ram_wren, ram_data, busy})), 64'd0);
  endtask

  task automatic txn_op(input logic wr, input logic [0:0] addr, input logic [47:0] wdata);
    int n = 0;
    txn_req = 1'b1; txn_wr = wr; txn_addr = addr; txn_wdata = wdata;
    do begin
      @(posedge clock); #1; n++;
    end while (!txn_ack && n < 50);
    check("txn_ack_timeout", 64'(txn_ack), 64'd1);
    txn_req = 1'b0;
  endtask

  task automatic disp_op(input logic [0:0] addr);
    int n = 0;
    disp_req = 1'b1; disp_addr = addr;
    do begin
      @(posedge clock); #1; n++;
    end while (!disp_ack && n < 80);
    check("disp_ack_timeout", 64'(disp_ack), 64'd1);
    disp_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock); #1; n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    txn_req = 1'b0; txn_wr = 1'b0; txn_addr = 1'b0; txn_wdata = 48'h0;
    disp_req = 1'b0; disp_addr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("in_reset");
    reset = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      check_all_zero("idle");
    end
    check("idle_no_wren", 64'(wren_cycles), 64'd0);

    // transaction write then read back
    push(2'd0, 1'b1, 48'h0, 48'h0);
    txn_op(1'b1, 1'b1, 48'h0000_00FF_0010);
    drain();
    check("write_wren_cycles", 64'(wren_cycles), 64'd1);
    check("mem_written", 64'(mem[1]), 64'h0000_00FF_0010);
    push(2'd0, 1'b0, 48'h0, 48'h0);
    push(2'd2, 1'b0, 48'h0000_00FF_0010, 48'h0);
    txn_op(1'b0, 1'b1, 48'h0);
    drain();

    // display read of preloaded word
    push(2'd1, 1'b0, 48'h0, 48'h0);
    push(2'd3, 1'b0, 48'h0000_0000_1234, 48'h0000_00FF_0010);
    disp_op(1'b0);
    drain();

    // simultaneous requests: transaction first
    push(2'd0, 1'b0, 48'h0, 48'h0);
    push(2'd2, 1'b0, 48'h0000_00FF_0010, 48'h0000_0000_1234);
    push(2'd1, 1'b0, 48'h0, 48'h0);
    push(2'd3, 1'b0, 48'h0000_0000_1234, 48'h0000_00FF_0010);
    fork
      txn_op(1'b0, 1'b1, 48'h0);
      disp_op(1'b0);
    join
    drain();

    // starvation guard: 4 transaction reads, display, then transaction resumes
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 1'b0, 48'h0, 48'h0);
      push(2'd2, 1'b0, 48'h0000_00FF_0010, 48'h0000_0000_1234);
    end
    push(2'd1, 1'b0, 48'h0, 48'h0);
    push(2'd3, 1'b0, 48'h0000_0000_1234, 48'h0000_00FF_0010);
    push(2'd0, 1'b0, 48'h0, 48'h0);
    push(2'd2, 1'b0, 48'h0000_00FF_0010, 48'h0000_0000_1234);
    fork
      begin
        int acks = 0;
        int n = 0;
        txn_req = 1'b1; txn_wr = 1'b0; txn_addr = 1'b1;
        while (acks < 5 && n < 200) begin
          @(posedge clock); #1; n++;
          if (txn_ack) acks++;
        end
        txn_req = 1'b0;
        check("starve_txn_acks", 64'(acks), 64'd5);
      end
      disp_op(1'b0);
    join
    drain();
    check("reads_no_wren", 64'(wren_cycles), 64'd1);

    // reset in the middle of a read
    push(2'd0, 1'b0, 48'h0, 48'h0);
    txn_op(1'b0, 1'b1, 48'h0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check_all_zero("after_abort");
    push(2'd1, 1'b0, 48'h0, 48'h0);
    push(2'd3, 1'b0, 48'h0000_0000_1234, 48'h0);
    disp_op(1'b0);
    drain();
    check("final_wren_cycles", 64'(wren_cycles), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
